// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register file slice.
//   DATA_W / ADDR_W / NUM_REGS : geometry (NUM_REGS must equal 2**ADDR_W)
//   reg_addr_t / reg_data_t    : address and data word types
//   rf_state_t                 : clear sequencer states (IDLE, CLEAR)
// Optional feature macro used by register_file: REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 6;
  localparam int NUM_REGS = 64;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_t;

  // Final address written by the clear sequence.
  localparam reg_addr_t LAST_ADDR = reg_addr_t'(NUM_REGS - 1);

endpackage

// File: rtl/regfile_clear_ctrl.sv
// regfile_clear_ctrl: bulk-clear sequencer for the register file.
// Ports:
//   clock       in  rising-edge clock
//   reset       in  asynchronous active-high reset
//   clear_req   in  request pulse; accepted only in IDLE
//   clr_active  out high while the sequencer is in CLEAR (array write owner)
//   clr_addr    out register currently being zeroed
//   busy        out registered busy flag, high for exactly NUM_REGS cycles
//   state_dbg   out current FSM state, for observation
// Once started, the sequence always runs to NUM_REGS-1; further requests
// are ignored rather than restarting the walk.
module regfile_clear_ctrl
  import regfile_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      clear_req,
  output logic      clr_active,
  output reg_addr_t clr_addr,
  output logic      busy,
  output rf_state_t state_dbg
);

  rf_state_t state;
  reg_addr_t counter;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      counter <= '0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state   <= CLEAR;
            counter <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          if (counter == LAST_ADDR) begin
            state   <= IDLE;
            counter <= '0;
            busy    <= 1'b0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          counter <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  assign clr_active = (state == CLEAR);
  assign clr_addr   = counter;
  assign state_dbg  = state;

endmodule

// File: rtl/register_file.sv
// register_file: architectural register file, 3 registered read ports and
// 2 write ports, with a bulk-clear sequencer for soft reinitialisation.
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   rd1/rd2/rd3             read addresses
//   rd1_out/rd2_out/rd3_out read data, one cycle after the address
//   wr1, wr1_data, wr1_enable  write port 1
//   wr2, wr2_data, wr2_enable  write port 2 (wins over port 1 on same address)
//   clear_req               pulse: zero all registers, one per cycle
//   busy                    high while the clear sequence runs
// Macro REGFILE_BYPASS_EN: when defined, a read of the address being written
// in the same cycle returns the new data (wr2 > wr1 > array), and a read of
// the entry being cleared returns 0. When undefined, reads always return the
// array contents as they were before the edge.
//
// Handshake: there is no flow control. Write strobes are single-cycle and
// are sampled on the rising edge; they are dropped (not queued) while busy.
// Reads are never stalled.
module register_file
  import regfile_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  input  reg_addr_t rd1,
  input  reg_addr_t rd2,
  input  reg_addr_t rd3,
  output reg_data_t rd1_out,
  output reg_data_t rd2_out,
  output reg_data_t rd3_out,
  input  reg_addr_t wr1,
  input  reg_data_t wr1_data,
  input  logic      wr1_enable,
  input  reg_addr_t wr2,
  input  reg_data_t wr2_data,
  input  logic      wr2_enable,
  input  logic      clear_req,
  output logic      busy
);

  reg_data_t mem [NUM_REGS];

  logic      clr_active;
  reg_addr_t clr_addr;
  rf_state_t clr_state;

  regfile_clear_ctrl u_clear_ctrl (
    .clock      (clock),
    .reset      (reset),
    .clear_req  (clear_req),
    .clr_active (clr_active),
    .clr_addr   (clr_addr),
    .busy       (busy),
    .state_dbg  (clr_state)
  );

  // Execute-stage writes only land while the sequencer is idle.
  logic wr1_go;
  logic wr2_go;
  assign wr1_go = wr1_enable && !clr_active;
  assign wr2_go = wr2_enable && !clr_active;

  // Array update. Port 2 is assigned last so it overrides port 1 when both
  // target the same register in one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_active) begin
      mem[clr_addr] <= '0;
    end else begin
      if (wr1_go) mem[wr1] <= wr1_data;
      if (wr2_go) mem[wr2] <= wr2_data;
    end
  end

  // Read-data selection for the three ports.
  reg_addr_t rd_addr [3];
  reg_data_t rd_next [3];

  assign rd_addr[0] = rd1;
  assign rd_addr[1] = rd2;
  assign rd_addr[2] = rd3;

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_next[p] = mem[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (wr2_go && (wr2 == rd_addr[p])) begin
        rd_next[p] = wr2_data;
      end else if (wr1_go && (wr1 == rd_addr[p])) begin
        rd_next[p] = wr1_data;
      end else if (clr_active && (clr_addr == rd_addr[p])) begin
        rd_next[p] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd1_out <= '0;
      rd2_out <= '0;
      rd3_out <= '0;
    end else begin
      rd1_out <= rd_next[0];
      rd2_out <= rd_next[1];
      rd3_out <= rd_next[2];
    end
  end

endmodule
